instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Initiator side of the instruction memory read port. Owns the fetch PC.
//   Drives read_address and pairs each returned 32-bit big-endian word with its PC.
//   The memory has 1-cycle registered latency: it samples read_address at a posedge
//   and returns instruction_in after that edge.
//   Delivers pc/instruction to decode with stall and branch-redirect support.
// PARAMETERS
//   RESET_PC   0    byte address fetched first after reset (multiple of 4)
//   MEM_BYTES  256  instruction memory size in bytes; PC wraps modulo this
// PORTS
//   clk              in   1   rising-edge clock
//   reset_n          in   1   asynchronous reset, active low
//   stall            in   1   decode not ready; hold current output
//   branch_taken     in   1   redirect fetch to branch_target
//   branch_target    in   32  byte address of redirect
//   read_address     out  32  byte address to instruction memory
//   instruction_in   in   32  word from instruction memory (valid 1 cycle after address)
//   pc_out           out  32  PC of instruction_out
//   instruction_out  out  32  fetched instruction
//   instr_valid      out  1   pc_out/instruction_out valid this cycle
//   misaligned_fault out  1   sticky; bad redirect target seen
// BEHAVIOUR
//   - Internal regs: fetch_pc, inflight_pc, inflight_v (word requested at last edge).
//   - Output regs: pc_out, instruction_out, instr_valid, misaligned_fault.
//   - Reset (async, reset_n=0): fetch_pc=RESET_PC, inflight_v=0, pc_out=0,
//     instruction_out=0, instr_valid=0, misaligned_fault=0, state=FILL.
//     read_address=RESET_PC while reset_n=0.
//   - read_address (combinational), by priority:
//     state FAULT -> fetch_pc; branch_taken -> branch_target;
//     stall -> inflight_pc; otherwise fetch_pc.
//   - Normal edge (no branch, no stall):
//     instruction_out<=instruction_in; pc_out<=inflight_pc; instr_valid<=inflight_v;
//     inflight_pc<=fetch_pc; inflight_v<=1; fetch_pc<=(fetch_pc+4)%MEM_BYTES.
//   - Latency: 2 edges from address issue to instr_valid. After reset release,
//     first valid (pc_out=RESET_PC) appears after the 2nd posedge.
//   - Stall edge: all regs hold. read_address=inflight_pc, so memory re-reads the
//     in-flight word and instruction_in stays paired with inflight_pc.
//     No instruction is skipped or duplicated.
//   - Branch edge (branch_taken=1):
//     - Stall is ignored; the displayed instruction counts as consumed.
//     - Target aligned and < MEM_BYTES: inflight_pc<=branch_target; inflight_v<=1;
//       fetch_pc<=(branch_target+4)%MEM_BYTES; instr_valid<=0 (wrong-path word flushed).
//     - Result: exactly 1 bubble cycle, then pc_out=branch_target.
//   - Fault: target[1:0]!=0 or target>=MEM_BYTES -> misaligned_fault<=1,
//     instr_valid<=0, inflight_v<=0, state=FAULT.
//     FAULT holds all regs, ignores stall/branch, and exits only via reset.
//   - States: FILL (inflight_v=0, instr_valid=0) -> RUN after the first edge.
//     RUN -> FAULT on bad target. Any state -> FILL on reset.
//   - Wrap: fetch_pc=MEM_BYTES-4 increments to 0. pc_out is always < MEM_BYTES.
//   - Reset mid-operation: outputs clear immediately (async), not at the next edge.
// TESTING
//   Memory preload: word@0=0x014B4822, @12=0xAC0A0004, others = address-tagged values.
//   1 Release reset, stall=0 -> read_address 0,4,8,..., first instr_valid after 2nd edge
//     with pc_out=0/0x014B4822, then pc_out 4,8,12 (0xAC0A0004) on consecutive cycles.
//   2 Hold stall=1 for 3 cycles while pc_out=4 -> pc_out/instruction held, read_address=8
//     during stall; after release pc_out=8 then 12, no gaps or repeats.
//   3 branch_taken=1, target=12, while pc_out=4 -> next cycle instr_valid=0,
//     then pc_out=12/0xAC0A0004, then 16.
//   4 branch_taken=1 and stall=1 same cycle, target=0 -> branch wins: bubble, then pc_out=0.
//   5 Branch to 252 -> pc_out 252 then 0 (wrap), instr_valid continuous.
//   6 Branch to 0x6 -> misaligned_fault=1 and instr_valid=0 after the edge, held for
//     10 cycles; pulse reset_n=0 mid-cycle -> fault and valid clear immediately,
//     then test 1 sequence repeats.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives the instruction memory
// read port and pairs each returned word with its PC for the decode stage.
// Supports decode back-pressure (stall) and branch redirects. A redirect to a
// misaligned or out-of-range target parks the unit in a sticky fault state
// that only reset clears.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] read_address,
    input  logic [31:0] instruction_in,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        instr_valid,
    output logic        misaligned_fault
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         inflight_v_q, inflight_v_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  instruction_out_q, instruction_out_d;
    logic         instr_valid_q, instr_valid_d;
    logic         misaligned_fault_q, misaligned_fault_d;
    logic         bad_target;

    // Next sequential word address, wrapping at the end of instruction memory.
    // Inputs are always below MEM_LIMIT, so a single subtract implements the modulo.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        logic [31:0] sum;
        sum = addr + 32'd4;
        if (sum >= MEM_LIMIT) begin
            sum = sum - MEM_LIMIT;
        end
        return sum;
    endfunction

    assign bad_target = (branch_target[1:0] != 2'b00) || (branch_target >= MEM_LIMIT);

    // Memory address select: a stall re-reads the in-flight word so the returned
    // data stays paired with inflight_pc; a redirect fetches the target at once.
    always_comb begin
        read_address = fetch_pc_q;
        if (!reset_n) begin
            read_address = RESET_PC;
        end else if (state_q == FAULT) begin
            read_address = fetch_pc_q;
        end else if (branch_taken) begin
            read_address = branch_target;
        end else if (stall) begin
            read_address = inflight_pc_q;
        end else begin
            read_address = fetch_pc_q;
        end
    end

    // Next-state logic for the fetch pipeline: branch beats stall, stall holds
    // everything, a normal edge shifts the in-flight word out to decode.
    always_comb begin
        state_d            = state_q;
        fetch_pc_d         = fetch_pc_q;
        inflight_pc_d      = inflight_pc_q;
        inflight_v_d       = inflight_v_q;
        pc_out_d           = pc_out_q;
        instruction_out_d  = instruction_out_q;
        instr_valid_d      = instr_valid_q;
        misaligned_fault_d = misaligned_fault_q;

        if (state_q != FAULT) begin
            if (branch_taken) begin
                if (bad_target) begin
                    misaligned_fault_d = 1'b1;
                    instr_valid_d      = 1'b0;
                    inflight_v_d       = 1'b0;
                    state_d            = FAULT;
                end else begin
                    inflight_pc_d = branch_target;
                    inflight_v_d  = 1'b1;
                    fetch_pc_d    = next_word(branch_target);
                    instr_valid_d = 1'b0;
                    state_d       = RUN;
                end
            end else if (!stall) begin
                instruction_out_d = instruction_in;
                pc_out_d          = inflight_pc_q;
                instr_valid_d     = inflight_v_q;
                inflight_pc_d     = fetch_pc_q;
                inflight_v_d      = 1'b1;
                fetch_pc_d        = next_word(fetch_pc_q);
                state_d           = RUN;
            end
        end
    end

    // State and output registers; reset clears the outputs immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= FILL;
            fetch_pc_q         <= RESET_PC;
            inflight_pc_q      <= RESET_PC;
            inflight_v_q       <= 1'b0;
            pc_out_q           <= 32'd0;
            instruction_out_q  <= 32'd0;
            instr_valid_q      <= 1'b0;
            misaligned_fault_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            fetch_pc_q         <= fetch_pc_d;
            inflight_pc_q      <= inflight_pc_d;
            inflight_v_q       <= inflight_v_d;
            pc_out_q           <= pc_out_d;
            instruction_out_q  <= instruction_out_d;
            instr_valid_q      <= instr_valid_d;
            misaligned_fault_q <= misaligned_fault_d;
        end
    end

    assign pc_out           = pc_out_q;
    assign instruction_out  = instruction_out_q;
    assign instr_valid      = instr_valid_q;
    assign misaligned_fault = misaligned_fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a 1-cycle registered instruction memory,
// a stream-level model of which PC decode should see, a negedge compare
// process, and directed sequences with literal expectations.
module tb_instruction_fetch_unit;

    localparam int MEM_BYTES = 256;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] read_address;
    logic [31:0] instruction_in;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        instr_valid;
    logic        misaligned_fault;

    int vectors;
    int miscompares;

    // Stream model: next PC decode will receive and how many edges until it shows
    logic [31:0] m_next_pc;
    int          m_wait;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_fault;

    instruction_fetch_unit #(
        .RESET_PC (32'd0),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .read_address    (read_address),
        .instruction_in  (instruction_in),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .instr_valid     (instr_valid),
        .misaligned_fault(misaligned_fault)
    );

    // Memory image: two known words, all others tagged with their byte address
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] a;
        a = {24'd0, addr[7:2], 2'b00};
        if (a == 32'd0) return 32'h014B4822;
        if (a == 32'd12) return 32'hAC0A0004;
        return 32'hCAFE0000 | a;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory with one cycle of registered read latency
    always @(posedge clk) begin
        instruction_in <= mem_word(read_address);
    end

    // Reference model of the delivered instruction stream
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_next_pc <= 32'd0;
            m_wait    <= 2;
            m_valid   <= 1'b0;
            m_pc      <= 32'd0;
            m_fault   <= 1'b0;
        end else if (!m_fault) begin
            if (branch_taken) begin
                if ((branch_target % 4) != 0 || branch_target >= MEM_BYTES) begin
                    m_fault <= 1'b1;
                    m_valid <= 1'b0;
                end else begin
                    m_valid   <= 1'b0;
                    m_next_pc <= branch_target;
                    m_wait    <= 1;
                end
            end else if (!stall) begin
                if (m_wait > 1) begin
                    m_wait  <= m_wait - 1;
                    m_valid <= 1'b0;
                end else begin
                    m_valid   <= 1'b1;
                    m_pc      <= m_next_pc;
                    m_next_pc <= (m_next_pc + 32'd4) % MEM_BYTES;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the stream model
    always @(negedge clk) begin
        logic [31:0] exp_ra;
        logic        ra_known;
        check_output("model_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        check_output("model_fault", {31'd0, misaligned_fault}, {31'd0, m_fault});
        if (m_valid) begin
            check_output("model_pc", pc_out, m_pc);
            check_output("model_instr", instruction_out, mem_word(m_pc));
        end
        ra_known = 1'b1;
        exp_ra   = 32'd0;
        if (!reset_n) exp_ra = 32'd0;
        else if (m_fault) ra_known = 1'b0;
        else if (branch_taken) exp_ra = branch_target;
        else if (stall) begin
            if (m_wait == 1) exp_ra = m_next_pc;
            else ra_known = 1'b0;
        end else if (m_wait == 1) exp_ra = (m_next_pc + 32'd4) % MEM_BYTES;
        else exp_ra = m_next_pc;
        if (ra_known) check_output("model_read_address", read_address, exp_ra);
    end

    // Drive inputs across exactly one rising edge, return just after it
    task automatic apply_stimulus(input logic st, input logic br, input logic [31:0] tgt);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] pc,
                              input logic [31:0] instr);
        check_output({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check_output({name, "_pc"}, pc_out, pc);
        check_output({name, "_instr"}, instruction_out, instr);
    endtask

    task automatic expect_bubble(input string name);
        check_output({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    // Reset release followed by the sequential fill sequence
    task automatic fill_sequence(input string tag);
        check_output({tag, "_ra_fill"}, read_address, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_bubble({tag, "_edge1"});
        check_output({tag, "_ra_edge1"}, read_address, 32'd4);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out({tag, "_first"}, 32'd0, 32'h014B4822);
        check_output({tag, "_ra_edge2"}, read_address, 32'd8);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out({tag, "_pc4"}, 32'd4, 32'hCAFE0004);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_valid", {31'd0, instr_valid}, 32'd0);
        check_output("reset_fault", {31'd0, misaligned_fault}, 32'd0);
        check_output("reset_pc", pc_out, 32'd0);
        check_output("reset_instr", instruction_out, 32'd0);
        check_output("reset_ra", read_address, 32'd0);
        reset_n = 1'b1;

        // Test 1: fill and sequential fetch
        fill_sequence("t1");

        // Test 2: stall three cycles with pc_out=4
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'd0);
            expect_out("t2_hold", 32'd4, 32'hCAFE0004);
            check_output("t2_ra_stall", read_address, 32'd8);
        end
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t2_after8", 32'd8, 32'hCAFE0008);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t2_after12", 32'd12, 32'hAC0A0004);

        // Return to pc_out=4 with a redirect, then test 3: branch to 12
        apply_stimulus(1'b0, 1'b1, 32'd4);
        expect_bubble("t3_pre_bubble");
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t3_pre_pc4", 32'd4, 32'hCAFE0004);
        apply_stimulus(1'b0, 1'b1, 32'd12);
        expect_bubble("t3_bubble");
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t3_pc12", 32'd12, 32'hAC0A0004);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t3_pc16", 32'd16, 32'hCAFE0010);

        // Test 4: branch and stall together, branch wins
        apply_stimulus(1'b1, 1'b1, 32'd0);
        expect_bubble("t4_bubble");
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t4_pc0", 32'd0, 32'h014B4822);

        // Test 5: branch to the last word and wrap
        apply_stimulus(1'b0, 1'b1, 32'd252);
        expect_bubble("t5_bubble");
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t5_pc252", 32'd252, 32'hCAFE00FC);
        check_output("t5_ra_wrap", read_address, 32'd4);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t5_wrap0", 32'd0, 32'h014B4822);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t5_pc4", 32'd4, 32'hCAFE0004);

        // Test 6: misaligned target faults, fault is sticky through activity
        apply_stimulus(1'b0, 1'b1, 32'h6);
        check_output("t6_fault", {31'd0, misaligned_fault}, 32'd1);
        expect_bubble("t6_bubble");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(logic'(i % 2), logic'(i % 3 == 0), 32'd8);
            check_output("t6_fault_hold", {31'd0, misaligned_fault}, 32'd1);
            expect_bubble("t6_hold");
        end
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t6_async_fault", {31'd0, misaligned_fault}, 32'd0);
        check_output("t6_async_valid", {31'd0, instr_valid}, 32'd0);
        check_output("t6_async_pc", pc_out, 32'd0);
        check_output("t6_async_ra", read_address, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        fill_sequence("t6r");
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t6r_pc8", 32'd8, 32'hCAFE0008);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        expect_out("t6r_pc12", 32'd12, 32'hAC0A0004);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
